// File: rtl/ecc_apb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ecc_apb_pkg
// Brief    : Shared types and register map for the ECC APB master.
// Revision : 1.0
// ============================================================================
package ecc_apb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        ACCESS    = 3'd2,
        WAIT_DONE = 3'd3,
        RESULT    = 3'd4
    } state_t;

    localparam logic [7:0] C_OFS_CTRL           = 8'h00;
    localparam logic [7:0] C_OFS_DATA_IN        = 8'h04;
    localparam logic [7:0] C_OFS_CODEWORD_WIDTH = 8'h08;
    localparam logic [7:0] C_OFS_NOISE          = 8'h0C;

    localparam logic [1:0] C_OP_ENC  = 2'd0;
    localparam logic [1:0] C_OP_DEC  = 2'd1;
    localparam logic [1:0] C_OP_FULL = 2'd2;

    localparam logic [1:0] C_LAST_IDX = 2'd3;

    // CTRL sits last in the sequence because writing it launches the operation.
    function automatic logic [7:0] wr_offset(input logic [1:0] idx);
        case (idx)
            2'd0:    wr_offset = C_OFS_DATA_IN;
            2'd1:    wr_offset = C_OFS_CODEWORD_WIDTH;
            2'd2:    wr_offset = C_OFS_NOISE;
            default: wr_offset = C_OFS_CTRL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_timeout_cnt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ecc_timeout_cnt
// Brief    : Clear/enable cycle counter with terminal flag at TIMEOUT_CYCLES-1.
// Revision : 1.0
// ============================================================================
module ecc_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_terminal
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] C_TERM = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_cnt;
    logic         w_term;

    assign w_term     = (r_cnt == C_TERM);
    assign o_terminal = w_term;

    // Holds at the terminal value so the count can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_term) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ecc_apb_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ecc_apb_master
// Brief    : Accepts one ECC job, programs it with four APB writes, returns result.
// Revision : 1.0
// ============================================================================
module ecc_apb_master
    import ecc_apb_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int TIMEOUT_CYCLES  = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [1:0]                 job_op,
    input  logic [AMBA_WORD-1:0]       job_data,
    input  logic [1:0]                 job_width,
    input  logic [AMBA_WORD-1:0]       job_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DATA_WIDTH-1:0]      res_data,
    output logic [1:0]                 res_errors,
    output logic                       res_timeout,
    output logic                       busy
);

    state_t                  r_state;
    state_t                  w_next;
    logic [1:0]              r_idx;
    logic [1:0]              r_op;
    logic [AMBA_WORD-1:0]    r_data;
    logic [1:0]              r_width;
    logic [AMBA_WORD-1:0]    r_noise;
    logic [DATA_WIDTH-1:0]   r_res_data;
    logic [1:0]              r_res_errors;
    logic                    r_res_timeout;
    logic                    w_in_wait;
    logic                    w_terminal;
    logic [AMBA_WORD-1:0]    w_wdata;

    assign w_in_wait = (r_state == WAIT_DONE);

    ecc_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (!w_in_wait),
        .i_en       (w_in_wait),
        .o_terminal (w_terminal)
    );

    always_comb begin
        case (r_idx)
            2'd0:    w_wdata = r_data;
            2'd1:    w_wdata = AMBA_WORD'(r_width);
            2'd2:    w_wdata = r_noise;
            default: w_wdata = AMBA_WORD'(r_op);
        endcase
    end

    always_comb begin
        w_next    = r_state;
        job_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        PWRITE    = 1'b0;
        PADDR     = '0;
        PWDATA    = '0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
                if (job_valid) w_next = SETUP;
            end
            SETUP: begin
                PSEL   = 1'b1;
                PWRITE = 1'b1;
                PADDR  = AMBA_ADDR_WIDTH'(wr_offset(r_idx));
                PWDATA = w_wdata;
                w_next = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                PWRITE  = 1'b1;
                PADDR   = AMBA_ADDR_WIDTH'(wr_offset(r_idx));
                PWDATA  = w_wdata;
                w_next  = (r_idx == C_LAST_IDX) ? WAIT_DONE : SETUP;
            end
            WAIT_DONE: begin
                if (operation_done || w_terminal) w_next = RESULT;
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_op          <= '0;
            r_data        <= '0;
            r_width       <= '0;
            r_noise       <= '0;
            r_res_data    <= '0;
            r_res_errors  <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (job_valid) begin
                        r_op    <= job_op;
                        r_data  <= job_data;
                        r_width <= job_width;
                        r_noise <= job_noise;
                        r_idx   <= '0;
                    end
                end
                ACCESS: begin
                    if (r_idx != C_LAST_IDX) r_idx <= r_idx + 1'b1;
                end
                WAIT_DONE: begin
                    // A done arriving on the terminal cycle still counts as success.
                    if (operation_done) begin
                        r_res_data    <= data_out;
                        r_res_errors  <= num_of_errors;
                        r_res_timeout <= 1'b0;
                    end else if (w_terminal) begin
                        r_res_data    <= '0;
                        r_res_errors  <= '0;
                        r_res_timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign res_data    = r_res_data;
    assign res_errors  = r_res_errors;
    assign res_timeout = r_res_timeout;

endmodule
`default_nettype wire
